// File: rtl/conv_filter_acc.sv
// conv_filter_acc: pipelined KSIZE x KSIZE fixed-point dot product accumulated over NCH
// channel beats, then bias, round-half-up, saturation and optional ReLU on each output.
module conv_filter_acc #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int KSIZE  = 3,
  parameter int NCH    = 4,
  parameter int ACC_W  = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [KSIZE*KSIZE*DATA_W-1:0] data_in,
  input  logic [KSIZE*KSIZE*DATA_W-1:0] weight_in,
  input  logic [DATA_W-1:0]             bias,
  input  logic                          relu_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_ovf
);

  localparam int TAPS   = KSIZE * KSIZE;
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);
  localparam logic signed [ACC_W-1:0] HALF    = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic                     w_adv;
  logic                     w_accept;
  logic                     w_first;
  logic                     w_last;
  logic signed [PROD_W-1:0] w_prod [TAPS];
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W-1:0]  w_next;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [DATA_W-1:0] w_clip;
  logic                     w_clip_ovf;
  logic [DATA_W-1:0]        w_res_data;

  logic [CNT_W-1:0]         r_cnt;
  logic                     r_s1_vld;
  logic                     r_s1_first;
  logic                     r_s1_last;
  logic                     r_s1_relu;
  logic signed [DATA_W-1:0] r_s1_bias;
  logic signed [PROD_W-1:0] r_s1_prod [TAPS];
  logic                     r_s2_vld;
  logic                     r_s2_first;
  logic                     r_s2_last;
  logic                     r_s2_relu;
  logic signed [DATA_W-1:0] r_s2_bias;
  logic signed [ACC_W-1:0]  r_s2_sum;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_out_data;
  logic                     r_out_ovf;

  // A held result freezes the whole pipeline, so nothing upstream can overrun it.
  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign w_accept  = in_valid && w_adv;
  assign w_first   = (r_cnt == {CNT_W{1'b0}});
  assign w_last    = (r_cnt == LAST_CNT);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

  // Per-tap signed products of the incoming window.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      w_prod[i] = PROD_W'($signed(data_in[i*DATA_W +: DATA_W])) *
                  PROD_W'($signed(weight_in[i*DATA_W +: DATA_W]));
    end
  end

  // Sign-extended adder tree over the registered products.
  always_comb begin
    w_sum = {ACC_W{1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      w_sum = w_sum + ACC_W'(r_s1_prod[i]);
    end
  end

  assign w_bias_ext = ACC_W'(r_s2_bias);
  assign w_base     = r_s2_first ? (w_bias_ext <<< FRAC_W) : r_acc;
  assign w_next     = w_base + r_s2_sum;
  assign w_rnd      = (w_next + HALF) >>> FRAC_W;

  // Saturate the rounded value to DATA_W, then apply ReLU to the clipped result.
  always_comb begin
    w_clip     = {DATA_W{1'b0}};
    w_clip_ovf = 1'b0;
    if (w_rnd > SAT_MAX) begin
      w_clip     = SAT_MAX[DATA_W-1:0];
      w_clip_ovf = 1'b1;
    end else if (w_rnd < SAT_MIN) begin
      w_clip     = SAT_MIN[DATA_W-1:0];
      w_clip_ovf = 1'b1;
    end else begin
      w_clip     = w_rnd[DATA_W-1:0];
      w_clip_ovf = 1'b0;
    end
    w_res_data = (r_s2_relu && w_clip[DATA_W-1]) ? {DATA_W{1'b0}} : w_clip;
  end

  // Beat counter plus stage-1 product and tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= {CNT_W{1'b0}};
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_relu  <= 1'b0;
      r_s1_bias  <= {DATA_W{1'b0}};
      for (int i = 0; i < TAPS; i++) begin
        r_s1_prod[i] <= {PROD_W{1'b0}};
      end
    end else if (w_adv) begin
      if (w_accept) begin
        r_cnt <= w_last ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
      end
      r_s1_vld   <= w_accept;
      r_s1_first <= w_first;
      r_s1_last  <= w_last;
      r_s1_relu  <= relu_en;
      r_s1_bias  <= bias;
      for (int i = 0; i < TAPS; i++) begin
        r_s1_prod[i] <= w_prod[i];
      end
    end
  end

  // Stage-2 sum, channel accumulator and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld    <= 1'b0;
      r_s2_first  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_relu   <= 1'b0;
      r_s2_bias   <= {DATA_W{1'b0}};
      r_s2_sum    <= {ACC_W{1'b0}};
      r_acc       <= {ACC_W{1'b0}};
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_s2_vld   <= r_s1_vld;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_relu  <= r_s1_relu;
      r_s2_bias  <= r_s1_bias;
      r_s2_sum   <= w_sum;
      if (r_s2_vld && !r_s2_last) begin
        r_acc <= w_next;
      end
      r_out_valid <= r_s2_vld && r_s2_last;
      if (r_s2_vld && r_s2_last) begin
        r_out_data <= w_res_data;
        r_out_ovf  <= w_clip_ovf;
      end
    end
  end

endmodule

// File: tb/tb_conv_filter_acc.sv
// Self-checking bench for conv_filter_acc: directed vector table, backpressure and reset
// sequences, and randomized groups scored against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_conv_filter_acc;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int KSIZE  = 3;
  localparam int NCH    = 4;
  localparam int ACC_W  = 40;
  localparam int TAPS   = KSIZE * KSIZE;
  localparam longint MAXV = (longint'(1) << (DATA_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DATA_W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [TAPS*DATA_W-1:0] data_in = '0;
  logic [TAPS*DATA_W-1:0] weight_in = '0;
  logic [DATA_W-1:0] bias = '0;
  logic relu_en = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic out_ovf;

  int n_checks = 0;
  int n_fail = 0;
  int n_hs = 0;
  int n0;
  logic rand_on;

  typedef struct { longint data; longint ovf; } res_t;
  res_t exp_q[$];
  int m_beat = 0;
  longint m_acc = 0;
  logic hold_pend = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic hold_ovf;

  typedef struct {
    longint d_all; longint w_all; longint d00; longint w00; longint bias;
    logic relu; longint exp_data; logic exp_ovf;
  } vec_t;
  vec_t vecs[13];

  conv_filter_acc #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .KSIZE(KSIZE), .NCH(NCH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .weight_in(weight_in), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference result: round half up, saturate, then ReLU.
  function automatic res_t model_out(input longint acc, input logic relu);
    res_t r;
    longint q;
    q = (acc + (longint'(1) << (FRAC_W - 1))) >>> FRAC_W;
    if (q > MAXV) begin r.data = MAXV; r.ovf = 1; end
    else if (q < MINV) begin r.data = MINV; r.ovf = 1; end
    else begin r.data = q; r.ovf = 0; end
    if (relu && r.data < 0) r.data = 0;
    return r;
  endfunction

  // Monitor and scoreboard: all interface signals are stable at the falling edge.
  always @(negedge clk) begin
    longint s;
    res_t e;
    if (rst) begin
      m_beat = 0;
      m_acc = 0;
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
        chk("hold_ovf", out_ovf, hold_ovf);
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_ovf = out_ovf;
      if (out_valid && out_ready) begin
        n_hs++;
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", longint'($signed(out_data)), e.data);
          chk("out_ovf", out_ovf, e.ovf);
        end
      end
      if (in_valid && in_ready) begin
        s = 0;
        for (int t = 0; t < TAPS; t++)
          s += longint'($signed(data_in[t*DATA_W +: DATA_W])) * longint'($signed(weight_in[t*DATA_W +: DATA_W]));
        if (m_beat == 0) m_acc = longint'($signed(bias)) * (longint'(1) << FRAC_W);
        m_acc += s;
        if (m_beat == NCH - 1) begin
          exp_q.push_back(model_out(m_acc, relu_en));
          m_beat = 0;
        end else m_beat++;
      end
    end
  end

  task automatic send_beat();
    int guard = 0;
    logic acc;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      guard++;
      if (guard > 500) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_group(input vec_t v);
    for (int b = 0; b < NCH; b++) begin
      for (int t = 0; t < TAPS; t++) begin
        data_in[t*DATA_W +: DATA_W]   = DATA_W'((b == 0 && t == 0) ? v.d00 : v.d_all);
        weight_in[t*DATA_W +: DATA_W] = DATA_W'((b == 0 && t == 0) ? v.w00 : v.w_all);
      end
      bias = DATA_W'(v.bias);
      relu_en = v.relu;
      send_beat();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{256, 256, 256, 256, 0, 1'b0, 9216, 1'b0};
    vecs[1]  = '{256, -256, 256, -256, 0, 1'b0, -9216, 1'b0};
    vecs[2]  = '{256, -256, 256, -256, 0, 1'b1, 0, 1'b0};
    vecs[3]  = '{32767, 32767, 32767, 32767, 0, 1'b0, 32767, 1'b1};
    vecs[4]  = '{32767, -32767, 32767, -32767, 0, 1'b0, -32768, 1'b1};
    vecs[5]  = '{32767, -32767, 32767, -32767, 0, 1'b1, 0, 1'b1};
    vecs[6]  = '{0, 0, 1, 128, 256, 1'b0, 257, 1'b0};
    vecs[7]  = '{0, 0, 1, 128, 0, 1'b0, 1, 1'b0};
    vecs[8]  = '{0, 0, -1, 128, 0, 1'b0, 0, 1'b0};
    vecs[9]  = '{0, 0, 1, 127, 0, 1'b0, 0, 1'b0};
    vecs[10] = '{0, 0, -1, 129, 0, 1'b0, -1, 1'b0};
    vecs[11] = '{0, 0, 0, 0, -32768, 1'b0, -32768, 1'b0};
    vecs[12] = '{0, 0, 0, 0, 32767, 1'b0, 32767, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors with exact two-edge latency.
    for (int i = 0; i < 13; i++) begin
      send_group(vecs[i]);
      for (int k = 1; k <= 2; k++) begin
        @(negedge clk);
        chk($sformatf("vec%0d_early_valid", i), out_valid, 0);
      end
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), longint'($signed(out_data)), vecs[i].exp_data);
      chk($sformatf("vec%0d_ovf", i), out_ovf, vecs[i].exp_ovf);
      @(posedge clk); #1;
    end

    // Backpressure: 3 groups offered while the output is blocked.
    out_ready = 1'b0;
    n0 = n_hs;
    fork
      begin
        for (int g = 0; g < 3; g++) begin
          vec_t v;
          v = '{256 * (g + 1), 256, 256 * (g + 1), 256, 0, 1'b0, 0, 1'b0};
          send_group(v);
        end
      end
      begin
        int k;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bp_held_valid", out_valid, 1);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_first_data", longint'($signed(out_data)), 9216);
        @(posedge clk); #1;
        k = 0;
        while (n_hs - n0 < 3 && k < 300) begin
          out_ready = (k % 3 == 2);
          @(posedge clk); #1;
          k++;
        end
        out_ready = 1'b0;
      end
    join
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_result_count", n_hs - n0, 3);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a group.
    n0 = n_hs;
    for (int t = 0; t < TAPS; t++) begin
      data_in[t*DATA_W +: DATA_W] = 16'sd256;
      weight_in[t*DATA_W +: DATA_W] = 16'sd256;
    end
    send_beat();
    send_beat();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send_group(vecs[0]);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_result_count", n_hs - n0, 1);
    chk("midrst_queue_empty", exp_q.size(), 0);

    // Randomized groups with random gaps and random downstream stalls.
    rand_on = 1'b1;
    fork
      begin
        for (int g = 0; g < 30; g++) begin
          for (int b = 0; b < NCH; b++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            for (int t = 0; t < TAPS; t++) begin
              if (g % 3 == 0) begin
                data_in[t*DATA_W +: DATA_W] = DATA_W'($urandom);
                weight_in[t*DATA_W +: DATA_W] = DATA_W'($urandom);
              end else begin
                data_in[t*DATA_W +: DATA_W] = DATA_W'(int'($urandom_range(0, 1023)) - 512);
                weight_in[t*DATA_W +: DATA_W] = DATA_W'(int'($urandom_range(0, 1023)) - 512);
              end
            end
            bias = DATA_W'($urandom);
            relu_en = 1'($urandom_range(0, 1));
            send_beat();
          end
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rand_drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
